// File: rtl/pad_bus_sequencer.sv
// Shares one bank of bidirectional pads between two requesters.
// Round-robin arbitration, bus-turnaround insertion on direction changes,
// one registered response per accepted transaction.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | pads released; accepts a transfer; response pulse appears here
// S_TURN  | pads released for TURN_CYCLES before a direction change
// S_WRITE | pads driven with the latched word for HOLD_CYCLES
// S_READ  | pads released for SAMPLE_DELAY; pad_din captured on last cycle
module pad_bus_sequencer #(
    parameter int WIDTH        = 8,
    parameter int HOLD_CYCLES  = 2,
    parameter int SAMPLE_DELAY = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_we,
    input  logic [2*WIDTH-1:0] req_wdata,
    output logic [1:0]         req_ready,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic [WIDTH-1:0]   pad_dout,
    output logic [WIDTH-1:0]   pad_oe,
    input  logic [WIDTH-1:0]   pad_din
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_DELAY - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = (TURN_CYCLES > 0) ? CNT_W'(TURN_CYCLES - 1) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               last_grant_q, last_grant_d;
    logic               last_dir_q, last_dir_d;   // 1 = write, 0 = read
    logic [WIDTH-1:0]   pad_oe_q, pad_oe_d;
    logic [WIDTH-1:0]   pad_dout_q, pad_dout_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic               win;
    logic [1:0]         grant;
    logic               start_op;
    logic               op_we;
    logic [WIDTH-1:0]   op_wdata;
    logic [WIDTH-1:0]   win_wdata;

    // Round-robin winner and combinational grant, only offered in IDLE
    always_comb begin
        win   = 1'b0;
        grant = 2'b00;
        case (req_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant_q;
            default: win = 1'b0;
        endcase
        if (state_q == S_IDLE && req_valid[win]) begin
            grant[win] = 1'b1;
        end
        win_wdata = win ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
    end

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        last_dir_d   = last_dir_q;
        pad_oe_d     = pad_oe_q;
        pad_dout_d   = pad_dout_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_rdata_d  = rsp_rdata_q;
        start_op     = 1'b0;
        op_we        = we_q;
        op_wdata     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    id_d         = win;
                    we_d         = req_we[win];
                    wdata_d      = win_wdata;
                    last_grant_d = win;
                    op_we        = req_we[win];
                    op_wdata     = win_wdata;
                    if (req_we[win] != last_dir_q && TURN_CYCLES > 0) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        start_op = 1'b1;
                    end
                end
            end
            S_TURN: begin
                if (cnt_q == '0) begin
                    start_op = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    pad_oe_d    = '0;
                    last_dir_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    last_dir_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_rdata_d = pad_din;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // pad_dout only moves on WRITE entry so the bus keeps its last word
        if (start_op) begin
            if (op_we) begin
                state_d    = S_WRITE;
                cnt_d      = HOLD_LOAD;
                pad_oe_d   = '1;
                pad_dout_d = op_wdata;
            end else begin
                state_d = S_READ;
                cnt_d   = SAMPLE_LOAD;
            end
        end
    end

    // State and output registers; reset releases the pads at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            last_dir_q   <= 1'b0;
            pad_oe_q     <= '0;
            pad_dout_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            last_dir_q   <= last_dir_d;
            pad_oe_q     <= pad_oe_d;
            pad_dout_q   <= pad_dout_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign pad_dout  = pad_dout_q;
    assign pad_oe    = pad_oe_q;

endmodule

// File: tb/tb_pad_bus_sequencer.sv
// Directed bench for pad_bus_sequencer: default instance plus a
// TURN_CYCLES=0 / HOLD_CYCLES=1 variant sharing clock and reset.
module tb_pad_bus_sequencer;

    logic        clk;
    logic        rst_n;

    logic [1:0]  req_valid, req_we, req_ready;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_id;
    logic [7:0]  rsp_rdata, pad_dout, pad_oe, pad_din;

    logic [1:0]  b_valid, b_we, b_ready;
    logic [15:0] b_wdata;
    logic        b_rsp_valid, b_rsp_id;
    logic [7:0]  b_rsp_rdata, b_dout, b_oe, b_din;

    int n_cmp = 0;
    int n_err = 0;

    pad_bus_sequencer #(.WIDTH(8), .HOLD_CYCLES(2), .SAMPLE_DELAY(2), .TURN_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .pad_dout(pad_dout), .pad_oe(pad_oe), .pad_din(pad_din)
    );

    pad_bus_sequencer #(.WIDTH(8), .HOLD_CYCLES(1), .SAMPLE_DELAY(2), .TURN_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_we(b_we), .req_wdata(b_wdata), .req_ready(b_ready),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_rdata(b_rsp_rdata),
        .pad_dout(b_dout), .pad_oe(b_oe), .pad_din(b_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; req_we = 2'b00; req_wdata = 16'h0; pad_din = 8'h00;
        b_valid = 2'b00; b_we = 2'b00; b_wdata = 16'h0; b_din = 8'h00;
        step();
        chk("rst_pad_oe", pad_oe, 8'h00);
        chk("rst_pad_dout", pad_dout, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_idle", req_ready, 2'b00);

        // Reset read: requester 1, no turnaround since last_dir = read
        step();
        pad_din = 8'hA5; req_valid = 2'b10; req_we = 2'b00;
        #1;
        chk("rd0_ready_c0", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        #1;
        chk("rd0_ready_c1", req_ready, 2'b00);
        chk("rd0_oe_c1", pad_oe, 8'h00);
        chk("rd0_rspv_c1", rsp_valid, 1'b0);
        step();
        chk("rd0_oe_c2", pad_oe, 8'h00);
        chk("rd0_rspv_c2", rsp_valid, 1'b0);
        step();
        chk("rd0_rspv_c3", rsp_valid, 1'b1);
        chk("rd0_id_c3", rsp_id, 1'b1);
        chk("rd0_rdata_c3", rsp_rdata, 8'hA5);
        chk("rd0_oe_c3", pad_oe, 8'h00);
        step();
        chk("rd0_rspv_c4", rsp_valid, 1'b0);

        // Write after read: requester 0 writes 0x3C through a TURN cycle
        req_valid = 2'b01; req_we = 2'b01; req_wdata = 16'h003C;
        #1;
        chk("wr0_ready_c0", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        chk("wr0_oe_c1_turn", pad_oe, 8'h00);
        step();
        chk("wr0_oe_c2", pad_oe, 8'hFF);
        chk("wr0_dout_c2", pad_dout, 8'h3C);
        step();
        chk("wr0_oe_c3", pad_oe, 8'hFF);
        chk("wr0_dout_c3", pad_dout, 8'h3C);
        chk("wr0_rspv_c3", rsp_valid, 1'b0);
        step();
        chk("wr0_rspv_c4", rsp_valid, 1'b1);
        chk("wr0_id_c4", rsp_id, 1'b0);
        chk("wr0_rdata_c4", rsp_rdata, 8'h00);
        chk("wr0_oe_c4", pad_oe, 8'h00);

        // Turnaround: requester 1 writes 0x11, then requester 0 reads
        step();
        req_valid = 2'b10; req_we = 2'b10; req_wdata = 16'h1100;
        #1;
        chk("ta_wr_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        #1;
        chk("ta_wr_oe_c1", pad_oe, 8'hFF);
        chk("ta_wr_dout_c1", pad_dout, 8'h11);
        step();
        chk("ta_wr_oe_c2", pad_oe, 8'hFF);
        step();
        chk("ta_wr_rspv_c3", rsp_valid, 1'b1);
        chk("ta_wr_id_c3", rsp_id, 1'b1);
        chk("ta_oe_c3_idle", pad_oe, 8'h00);
        pad_din = 8'h5A; req_valid = 2'b01; req_we = 2'b00;
        #1;
        chk("ta_rd_ready_c3", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        chk("ta_oe_c4_turn", pad_oe, 8'h00);
        chk("ta_rspv_c4", rsp_valid, 1'b0);
        step();
        chk("ta_oe_c5_read", pad_oe, 8'h00);
        chk("ta_dout_hold_c5", pad_dout, 8'h11);
        step();
        chk("ta_rspv_c6", rsp_valid, 1'b0);
        step();
        chk("ta_rd_rspv_c7", rsp_valid, 1'b1);
        chk("ta_rd_id_c7", rsp_id, 1'b0);
        chk("ta_rd_rdata_c7", rsp_rdata, 8'h5A);

        // Fairness: both requesters hold writes from reset
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_valid = 2'b11; req_we = 2'b11; req_wdata = 16'h2277;
        #1;
        chk("fair_ready_first", req_ready, 2'b01);
        step();
        chk("fair_oe_turn", pad_oe, 8'h00);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("fair_oe_write", pad_oe, 8'hFF);
            chk("fair_dout", pad_dout, (k % 2 == 0) ? 8'h77 : 8'h22);
            step();
            chk("fair_oe_write2", pad_oe, 8'hFF);
            step();
            chk("fair_rspv", rsp_valid, 1'b1);
            chk("fair_rsp_id", rsp_id, k % 2);
            chk("fair_oe_gap", pad_oe, 8'h00);
            chk("fair_ready_next", req_ready, ((k + 1) % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end

        // Reset mid-write: requester 0 was just granted, now in first WRITE cycle
        chk("mid_oe_w1", pad_oe, 8'hFF);
        step();
        chk("mid_oe_w2", pad_oe, 8'hFF);
        #2;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("mid_oe_async", pad_oe, 8'h00);
        step();
        chk("mid_rspv_a", rsp_valid, 1'b0);
        rst_n = 1'b1;
        step();
        chk("mid_rspv_b", rsp_valid, 1'b0);
        chk("mid_oe_b", pad_oe, 8'h00);
        req_valid = 2'b11; req_we = 2'b00;
        #1;
        chk("mid_tie_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("mid_rd_rspv", rsp_valid, 1'b1);
        chk("mid_rd_id", rsp_id, 1'b0);

        // Variant: no turnaround, single-cycle hold
        b_valid = 2'b01; b_we = 2'b01; b_wdata = 16'h009C;
        #1;
        chk("var_wr_ready", b_ready, 2'b01);
        step();
        b_valid = 2'b00;
        #1;
        chk("var_wr_oe_c1", b_oe, 8'hFF);
        chk("var_wr_dout_c1", b_dout, 8'h9C);
        step();
        chk("var_wr_rspv_c2", b_rsp_valid, 1'b1);
        chk("var_wr_id_c2", b_rsp_id, 1'b0);
        chk("var_wr_rdata_c2", b_rsp_rdata, 8'h00);
        chk("var_oe_c2", b_oe, 8'h00);
        b_din = 8'h3E; b_valid = 2'b10; b_we = 2'b00;
        #1;
        chk("var_rd_ready_c2", b_ready, 2'b10);
        step();
        b_valid = 2'b00;
        #1;
        chk("var_rd_oe_c3", b_oe, 8'h00);
        step();
        chk("var_rd_rspv_c4", b_rsp_valid, 1'b0);
        step();
        chk("var_rd_rspv_c5", b_rsp_valid, 1'b1);
        chk("var_rd_id_c5", b_rsp_id, 1'b1);
        chk("var_rd_rdata_c5", b_rsp_rdata, 8'h3E);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
